// File: rtl/proc_hazard_pkg.sv
// Shared types for the hazard unit: op classes, bypass-select codes and the
// per-stage control slice carried through X, M and W.
package proc_hazard_pkg;

  typedef enum logic [1:0] {
    CLS_ALU  = 2'd0,
    CLS_MUL  = 2'd1,
    CLS_LW   = 2'd2,
    CLS_NONE = 2'd3
  } cls_e;

  localparam logic [1:0] BYP_RF = 2'd0;
  localparam logic [1:0] BYP_X  = 2'd1;
  localparam logic [1:0] BYP_M  = 2'd2;
  localparam logic [1:0] BYP_W  = 2'd3;

  // Slices hold rd at a fixed width; the top zero-extends narrower addresses.
  localparam int unsigned SliceAw = 8;

  typedef struct packed {
    logic               val;
    logic               wen;
    logic [SliceAw-1:0] rd;
    cls_e               cls;
  } slice_t;

  localparam slice_t SLICE_BUBBLE = '{val: 1'b0, wen: 1'b0, rd: '0, cls: CLS_ALU};

  // A slice that architecturally writes a register (x0 never counts).
  function automatic logic writes_reg(slice_t s);
    return s.val & s.wen & (s.rd != '0);
  endfunction

endpackage

// File: rtl/proc_hazard_stage_reg.sv
// One pipeline-stage control slice: async-reset, enable-gated register.
module proc_hazard_stage_reg
  import proc_hazard_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   en_i,
  input  slice_t d_i,
  output slice_t q_o
);

  slice_t slice_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slice_q <= '0;
    end else if (en_i) begin
      slice_q <= d_i;
    end
  end

  assign q_o = slice_q;

endmodule

// File: rtl/proc_hazard_unit.sv
// Hazard unit for the 5-stage pipeline: owns X/M/W control slices, holds X for a
// multi-cycle MUL, and produces stall, bypass-select and RF-write controls.
module proc_hazard_unit
  import proc_hazard_pkg::*;
#(
  parameter int unsigned AW      = 5,
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned CW      = $clog2(MUL_LAT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          d_val,
  input  logic          d_squash,
  input  logic          d_rs1_en,
  input  logic [AW-1:0] d_rs1,
  input  logic          d_rs2_en,
  input  logic [AW-1:0] d_rs2,
  input  logic          d_wen,
  input  logic [AW-1:0] d_rd,
  input  logic [1:0]    d_cls,
  output logic          stall_D,
  output logic          reg_en_F,
  output logic          reg_en_D,
  output logic          busy_X,
  output logic          mul_start_X,
  output logic [1:0]    op1_byp_sel_D,
  output logic [1:0]    op2_byp_sel_D,
  output logic          val_X,
  output logic          val_M,
  output logic          val_W,
  output logic          rf_wen_W,
  output logic [AW-1:0] rf_waddr_W
);

  slice_t x_q, m_q, w_q;
  slice_t x_d, m_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic mul_start_q, mul_start_d;
  logic issue, d_is_mul;
  logic x1, x2, m1, m2, w1, w2, raw_stall;

  function automatic logic writer_match(slice_t s, logic [AW-1:0] rs, logic rs_en, logic dv);
    return writes_reg(s) & (s.rd == SliceAw'(rs)) & rs_en & dv;
  endfunction

  assign busy_X   = x_q.val & (cnt_q != '0);
  assign d_is_mul = (d_cls == CLS_MUL);

  assign x1 = writer_match(x_q, d_rs1, d_rs1_en, d_val);
  assign x2 = writer_match(x_q, d_rs2, d_rs2_en, d_val);
  assign m1 = writer_match(m_q, d_rs1, d_rs1_en, d_val);
  assign m2 = writer_match(m_q, d_rs2, d_rs2_en, d_val);
  assign w1 = writer_match(w_q, d_rs1, d_rs1_en, d_val);
  assign w2 = writer_match(w_q, d_rs2, d_rs2_en, d_val);

  // A busy MUL or an LW in X cannot forward yet.
  assign raw_stall = (x1 | x2) & (busy_X | (x_q.cls == CLS_LW));
  assign stall_D   = d_val & ~d_squash & (raw_stall | busy_X);
  assign reg_en_F  = ~stall_D;
  assign reg_en_D  = ~stall_D;
  assign issue     = d_val & ~d_squash & ~stall_D;

  always_comb begin
    op1_byp_sel_D = BYP_RF;
    if (x1 & ~stall_D)   op1_byp_sel_D = BYP_X;
    else if (m1)         op1_byp_sel_D = BYP_M;
    else if (w1)         op1_byp_sel_D = BYP_W;
    op2_byp_sel_D = BYP_RF;
    if (x2 & ~stall_D)   op2_byp_sel_D = BYP_X;
    else if (m2)         op2_byp_sel_D = BYP_M;
    else if (w2)         op2_byp_sel_D = BYP_W;
  end

  always_comb begin
    x_d         = SLICE_BUBBLE;
    cnt_d       = '0;
    mul_start_d = 1'b0;
    if (issue) begin
      x_d = '{val: 1'b1, wen: d_wen, rd: SliceAw'(d_rd), cls: cls_e'(d_cls)};
    end
    if (busy_X) begin
      cnt_d = cnt_q - CW'(1);
    end else if (issue & d_is_mul) begin
      cnt_d       = CW'(MUL_LAT - 1);
      mul_start_d = 1'b1;
    end
    m_d = busy_X ? SLICE_BUBBLE : x_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      mul_start_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      mul_start_q <= mul_start_d;
    end
  end

  proc_hazard_stage_reg u_x_reg (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (~busy_X),
    .d_i   (x_d),
    .q_o   (x_q)
  );

  proc_hazard_stage_reg u_m_reg (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (1'b1),
    .d_i   (m_d),
    .q_o   (m_q)
  );

  proc_hazard_stage_reg u_w_reg (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (1'b1),
    .d_i   (m_q),
    .q_o   (w_q)
  );

  assign mul_start_X = mul_start_q & x_q.val & (x_q.cls == CLS_MUL);
  assign val_X       = x_q.val;
  assign val_M       = m_q.val;
  assign val_W       = w_q.val;
  assign rf_wen_W    = writes_reg(w_q);
  assign rf_waddr_W  = rf_wen_W ? w_q.rd[AW-1:0] : '0;

endmodule

// File: tb/tb_proc_hazard_unit.sv
// Self-checking bench for proc_hazard_unit: directed scenarios plus random
// traffic against a timeline model of in-flight instructions.
module tb_proc_hazard_unit;

  localparam int AW = 5;
  localparam int MUL_LAT = 3;
  localparam int C_ALU = 0, C_MUL = 1, C_LW = 2, C_NONE = 3;

  logic clk = 1'b0, rst = 1'b1;
  logic d_val = 0, d_squash = 0, d_rs1_en = 0, d_rs2_en = 0, d_wen = 0;
  logic [AW-1:0] d_rs1 = '0, d_rs2 = '0, d_rd = '0;
  logic [1:0] d_cls = '0;
  logic stall_D, reg_en_F, reg_en_D, busy_X, mul_start_X, val_X, val_M, val_W, rf_wen_W;
  logic [1:0] op1_byp_sel_D, op2_byp_sel_D;
  logic [AW-1:0] rf_waddr_W;

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  proc_hazard_unit #(.AW(AW), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .d_val(d_val), .d_squash(d_squash),
    .d_rs1_en(d_rs1_en), .d_rs1(d_rs1), .d_rs2_en(d_rs2_en), .d_rs2(d_rs2),
    .d_wen(d_wen), .d_rd(d_rd), .d_cls(d_cls),
    .stall_D(stall_D), .reg_en_F(reg_en_F), .reg_en_D(reg_en_D), .busy_X(busy_X),
    .mul_start_X(mul_start_X), .op1_byp_sel_D(op1_byp_sel_D),
    .op2_byp_sel_D(op2_byp_sel_D), .val_X(val_X), .val_M(val_M), .val_W(val_W),
    .rf_wen_W(rf_wen_W), .rf_waddr_W(rf_waddr_W)
  );

  // Each issued instruction occupies X over [xe, xl), is in M at xl, in W at xl+1.
  typedef struct {int rd; bit wen; int cls; int xe; int xl;} minsn_t;
  minsn_t mq[$];
  int t = 0;
  bit e_stall, e_busy, e_ms, e_vx, e_vm, e_vw, e_wen;
  int e_s1, e_s2, e_waddr;

  function automatic bit wmatch(int idx, int rs, bit en);
    if (idx < 0) return 0;
    return mq[idx].wen && mq[idx].rd != 0 && mq[idx].rd == rs && en && d_val;
  endfunction

  task automatic model_eval();
    int xi = -1, mi = -1, wi = -1;
    bit x1, x2, raw;
    foreach (mq[i]) begin
      if (mq[i].xe <= t && t < mq[i].xl) xi = i;
      if (mq[i].xl == t) mi = i;
      if (mq[i].xl + 1 == t) wi = i;
    end
    e_busy = (xi >= 0) && (t < mq[xi].xl - 1);
    x1 = wmatch(xi, int'(d_rs1), d_rs1_en);
    x2 = wmatch(xi, int'(d_rs2), d_rs2_en);
    raw = (x1 || x2) && (e_busy || mq[xi].cls == C_LW);
    e_stall = d_val && !d_squash && (raw || e_busy);
    e_s1 = (x1 && !e_stall) ? 1 : wmatch(mi, int'(d_rs1), d_rs1_en) ? 2 :
           wmatch(wi, int'(d_rs1), d_rs1_en) ? 3 : 0;
    e_s2 = (x2 && !e_stall) ? 1 : wmatch(mi, int'(d_rs2), d_rs2_en) ? 2 :
           wmatch(wi, int'(d_rs2), d_rs2_en) ? 3 : 0;
    e_ms = (xi >= 0) && mq[xi].cls == C_MUL && t == mq[xi].xe;
    e_vx = (xi >= 0);
    e_vm = (mi >= 0);
    e_vw = (wi >= 0);
    e_wen = (wi >= 0) && mq[wi].wen && mq[wi].rd != 0;
    e_waddr = e_wen ? mq[wi].rd : 0;
  endtask

  task automatic tick();
    minsn_t n;
    model_eval();
    if (d_val && !d_squash && !e_stall) begin
      n.rd = int'(d_rd); n.wen = d_wen; n.cls = int'(d_cls); n.xe = t + 1;
      n.xl = t + 1 + ((int'(d_cls) == C_MUL) ? MUL_LAT : 1);
      mq.push_back(n);
    end
    @(posedge clk);
    t++;
    for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].xl + 1 < t) mq.delete(i);
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input bit sq, input int cls, input int rd, input bit wen,
                       input bit r1en, input int r1, input bit r2en, input int r2);
    d_val = v; d_squash = sq; d_cls = 2'(cls); d_rd = AW'(rd); d_wen = wen;
    d_rs1_en = r1en; d_rs1 = AW'(r1); d_rs2_en = r2en; d_rs2 = AW'(r2);
  endtask

  task automatic idle();
    drive(0, 0, C_NONE, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    t = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    #1;
    total++; if (stall_D !== 0 || reg_en_F !== 1 || reg_en_D !== 1) begin
      bad++; $display("FAIL reset_stall: got %b%b%b want 011", stall_D, reg_en_F, reg_en_D); end
    total++; if (busy_X !== 0 || mul_start_X !== 0) begin
      bad++; $display("FAIL reset_busy: got %b%b want 00", busy_X, mul_start_X); end
    total++; if (op1_byp_sel_D !== 0 || op2_byp_sel_D !== 0) begin
      bad++; $display("FAIL reset_sel: got %0d %0d want 0 0", op1_byp_sel_D, op2_byp_sel_D); end
    total++; if ({val_X, val_M, val_W, rf_wen_W} !== 4'b0 || rf_waddr_W !== '0) begin
      bad++; $display("FAIL reset_stage: got %b%b%b%b %0d want 0000 0",
                      val_X, val_M, val_W, rf_wen_W, rf_waddr_W); end
    do_reset();
  endtask

  task automatic test_mul_stall();
    do_reset();
    drive(1, 0, C_MUL, 3, 1, 1, 1, 1, 2);  // mul x3
    #1;
    total++; if (stall_D !== 0) begin bad++; $display("FAIL mul_T0_stall: got %b want 0", stall_D); end
    tick();
    drive(1, 0, C_ALU, 4, 1, 1, 3, 1, 1);  // add x4,x3,x1
    #1;
    total++; if ({stall_D, busy_X, mul_start_X} !== 3'b111) begin
      bad++; $display("FAIL mul_T1: got %b%b%b want 111", stall_D, busy_X, mul_start_X); end
    tick(); #1;
    total++; if ({stall_D, busy_X, mul_start_X, val_M} !== 4'b1100) begin
      bad++; $display("FAIL mul_T2: got %b%b%b%b want 1100", stall_D, busy_X, mul_start_X, val_M); end
    tick(); #1;
    total++; if ({stall_D, busy_X, mul_start_X, val_M} !== 4'b0000 || op1_byp_sel_D !== 2'd1) begin
      bad++; $display("FAIL mul_T3: got %b%b%b%b sel %0d want 0000 sel 1",
                      stall_D, busy_X, mul_start_X, val_M, op1_byp_sel_D); end
    tick(); idle(); #1;
    total++; if ({val_X, val_M} !== 2'b11) begin
      bad++; $display("FAIL mul_T4_adv: got %b%b want 11", val_X, val_M); end
  endtask

  task automatic test_lw_bypass();
    do_reset();
    drive(1, 0, C_LW, 5, 1, 1, 2, 0, 0);  // lw x5
    tick();
    drive(1, 0, C_ALU, 6, 1, 1, 5, 1, 5);  // add x6,x5,x5
    #1;
    total++; if (stall_D !== 1 || reg_en_D !== 0) begin
      bad++; $display("FAIL lw_stall: got %b%b want 10", stall_D, reg_en_D); end
    tick(); #1;
    total++; if (stall_D !== 0 || op1_byp_sel_D !== 2 || op2_byp_sel_D !== 2) begin
      bad++; $display("FAIL lw_byp: got %b %0d %0d want 0 2 2", stall_D, op1_byp_sel_D, op2_byp_sel_D); end
  endtask

  task automatic test_x_beats_m();
    do_reset();
    drive(1, 0, C_ALU, 1, 1, 1, 0, 0, 0);
    tick();
    drive(1, 0, C_ALU, 1, 1, 1, 1, 0, 0);
    tick();
    drive(1, 0, C_ALU, 2, 1, 1, 1, 1, 0);
    #1;
    total++; if (stall_D !== 0 || op1_byp_sel_D !== 1 || op2_byp_sel_D !== 0) begin
      bad++; $display("FAIL x_beats_m: got %b %0d %0d want 0 1 0", stall_D, op1_byp_sel_D, op2_byp_sel_D); end
  endtask

  task automatic test_x0();
    do_reset();
    drive(1, 0, C_LW, 0, 1, 0, 0, 0, 0);  // lw x0
    tick();
    drive(1, 0, C_NONE, 0, 0, 1, 0, 1, 0);
    #1;
    total++; if (stall_D !== 0 || op1_byp_sel_D !== 0 || op2_byp_sel_D !== 0) begin
      bad++; $display("FAIL x0_read: got %b %0d %0d want 0 0 0", stall_D, op1_byp_sel_D, op2_byp_sel_D); end
    tick(); idle(); tick(); #1;
    total++; if (val_W !== 1 || rf_wen_W !== 0 || rf_waddr_W !== '0) begin
      bad++; $display("FAIL x0_wb: got %b%b %0d want 10 0", val_W, rf_wen_W, rf_waddr_W); end
  endtask

  task automatic test_squash();
    do_reset();
    drive(1, 0, C_LW, 7, 1, 1, 1, 0, 0);
    tick();
    drive(1, 1, C_ALU, 8, 1, 1, 7, 0, 0);
    #1;
    total++; if (stall_D !== 0 || reg_en_F !== 1) begin
      bad++; $display("FAIL squash_stall: got %b%b want 01", stall_D, reg_en_F); end
    tick(); idle(); #1;
    total++; if (val_X !== 0) begin bad++; $display("FAIL squash_valx: got %b want 0", val_X); end
  endtask

  task automatic test_reset_mid_mul();
    do_reset();
    drive(1, 0, C_MUL, 3, 1, 0, 0, 0, 0);
    tick(); idle(); tick(); #1;
    total++; if (busy_X !== 1) begin bad++; $display("FAIL midmul_busy: got %b want 1", busy_X); end
    #1 rst = 1'b1;
    #1;
    total++; if ({busy_X, val_X, val_M, val_W, rf_wen_W} !== 5'b0) begin
      bad++; $display("FAIL midmul_async: got %b%b%b%b%b want 00000",
                      busy_X, val_X, val_M, val_W, rf_wen_W); end
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    t = 0;
    drive(1, 0, C_ALU, 9, 1, 1, 0, 0, 0);  // addi x9
    tick(); idle(); tick(); #1;
    total++; if (rf_wen_W !== 0) begin bad++; $display("FAIL addi_early: got %b want 0", rf_wen_W); end
    tick(); #1;
    total++; if (rf_wen_W !== 1 || rf_waddr_W !== AW'(9)) begin
      bad++; $display("FAIL addi_wb: got %b %0d want 1 9", rf_wen_W, rf_waddr_W); end
  endtask

  task automatic test_random();
    logic [17:0] got, exp;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 9) < 8), ($urandom_range(0, 9) == 0), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
            int'($urandom_range(0, 7)), 1'($urandom), int'($urandom_range(0, 7)));
      #1;
      model_eval();
      got = {stall_D, reg_en_F, reg_en_D, busy_X, mul_start_X, op1_byp_sel_D, op2_byp_sel_D,
             val_X, val_M, val_W, rf_wen_W, rf_waddr_W};
      exp = {e_stall, !e_stall, !e_stall, e_busy, e_ms, 2'(e_s1), 2'(e_s2),
             e_vx, e_vm, e_vw, e_wen, AW'(e_waddr)};
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL random_cycle%0d: got %h want %h", n, got, exp);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_mul_stall();
    test_lw_bypass();
    test_x_beats_m();
    test_x0();
    test_squash();
    test_reset_mid_mul();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
